divisao_matriz_num: RTL

// - Sequential divider: divides each signed element of a 5x5 matrix by a signed integer scalar.
// - Inverse companion of the combinational scalar-by-matrix multiplier in the same matrix ALU.
// - Shares that multiplier's packed matrix format: element i is at [(i*W) +: W].
// - Operates as a multi-cycle operation unit with a start/done handshake.
// - Uses one shared restoring divider, reused element by element.

---
 rtl/divisao_matriz_num.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/divisao_matriz_num.sv
// ============================================================================
// divisao_matriz_num
// ----------------------------------------------------------------------------
// Sequential divider for the matrix ALU. It divides every signed element of a
// 5x5 matrix by one signed scalar. It is the inverse companion of the
// combinational scalar-by-matrix multiplier.
//
// A single W-bit restoring divider is reused for each element in turn. Each
// element takes W+2 cycles: PREP (1) + DIV (W) + WRITE (1).
//
// Packed matrix format, shared with the multiplier: element i is at
// [(i*W) +: W], two's complement.
//
// Ports
//   clk            in   1         clock, rising edge
//   rst            in   1         asynchronous reset, active-high
//   start          in   1         request pulse, sampled only in IDLE
//   matriz_A       in   N_ELEM*W  dividend matrix, captured on accept
//   num_inteiro    in   W         signed divisor, captured on accept
//   nova_matriz_A  out  N_ELEM*W  quotient matrix
//   busy           out  1         high from the accepting edge until DONE is left
//   done           out  1         one-cycle completion pulse
//   overflow_flag  out  1         some element computed (-2^(W-1)) / (-1)
//   div_zero_flag  out  1         operation aborted, divisor was zero
//   resto_matriz_A out  N_ELEM*W  signed remainders (only with DIVISAO_RESTO_EN)
//
// Optional feature: define DIVISAO_RESTO_EN to add the resto_matriz_A
// remainder output. The remainder takes the sign of the dividend.
//
// Quotients truncate toward zero. The overflow case -128 / -1 wraps to 0x80.
// ============================================================================
module divisao_matriz_num #(
    parameter int N_ELEM = 25,
    parameter int W      = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [N_ELEM*W-1:0] matriz_A,
    input  logic [W-1:0]        num_inteiro,
    output logic [N_ELEM*W-1:0] nova_matriz_A,
    output logic                busy,
    output logic                done,
    output logic                overflow_flag,
    output logic                div_zero_flag
`ifdef DIVISAO_RESTO_EN
    ,
    output logic [N_ELEM*W-1:0] resto_matriz_A
`endif
);

    localparam int IDX_W = (N_ELEM > 1) ? $clog2(N_ELEM) : 1;
    localparam int CNT_W = $clog2(W + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_DIV,
        S_WRITE,
        S_DONE
    } state_t;

    state_t               state_q;
    logic [IDX_W-1:0]     idx_q;
    logic [CNT_W-1:0]     cnt_q;

    // Operands captured at accept, so later input changes have no effect
    logic [N_ELEM*W-1:0]  mat_q;
    logic [W-1:0]         dvs_q;

    // Restoring divider state. The dividend magnitude is shifted out of quo_q
    // MSB-first while quotient bits are shifted in at the LSB.
    logic [W-1:0]         rem_q;
    logic [W-1:0]         quo_q;
    logic [W-1:0]         dsr_q;
    logic                 qsign_q;
`ifdef DIVISAO_RESTO_EN
    logic                 rsign_q;
    logic [W-1:0]         r_signed;
`endif

    logic [W-1:0]         elem_w;
    logic                 a_neg;
    logic                 d_neg;
    logic [W-1:0]         a_mag;
    logic [W-1:0]         d_mag;
    logic [W:0]           rem_sh;
    logic [W:0]           diff;
    logic [W-1:0]         rem_d;
    logic [W-1:0]         quo_d;
    logic [W-1:0]         q_signed;
    logic                 ovf_elem;

    always_comb begin
        elem_w   = mat_q[int'(idx_q)*W +: W];
        a_neg    = elem_w[W-1];
        d_neg    = dvs_q[W-1];

        // Negating -2^(W-1) in W bits yields the same bit pattern.
        // Read as unsigned, that pattern is the correct magnitude 2^(W-1).
        a_mag    = a_neg ? -elem_w : elem_w;
        d_mag    = d_neg ? -dvs_q  : dvs_q;

        // One restoring step. The extra bit of diff is the borrow.
        rem_sh   = {rem_q, quo_q[W-1]};
        diff     = rem_sh - {1'b0, dsr_q};
        if (!diff[W]) begin
            rem_d = diff[W-1:0];
            quo_d = {quo_q[W-2:0], 1'b1};
        end else begin
            rem_d = rem_sh[W-1:0];
            quo_d = {quo_q[W-2:0], 1'b0};
        end

        // A magnitude of 2^(W-1) with a positive sign wraps to 0x80
        q_signed = qsign_q ? -quo_q : quo_q;
`ifdef DIVISAO_RESTO_EN
        r_signed = rsign_q ? -rem_q : rem_q;
`endif
        ovf_elem = (elem_w == {1'b1, {(W-1){1'b0}}}) && (dvs_q == '1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            idx_q         <= '0;
            cnt_q         <= '0;
            mat_q         <= '0;
            dvs_q         <= '0;
            rem_q         <= '0;
            quo_q         <= '0;
            dsr_q         <= '0;
            qsign_q       <= 1'b0;
            nova_matriz_A <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            overflow_flag <= 1'b0;
            div_zero_flag <= 1'b0;
`ifdef DIVISAO_RESTO_EN
            rsign_q        <= 1'b0;
            resto_matriz_A <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        mat_q         <= matriz_A;
                        dvs_q         <= num_inteiro;
                        idx_q         <= '0;
                        busy          <= 1'b1;
                        overflow_flag <= 1'b0;
                        if (num_inteiro == '0) begin
                            // Abort: zero the results and report completion
                            div_zero_flag <= 1'b1;
                            nova_matriz_A <= '0;
`ifdef DIVISAO_RESTO_EN
                            resto_matriz_A <= '0;
`endif
                            done          <= 1'b1;
                            state_q       <= S_DONE;
                        end else begin
                            div_zero_flag <= 1'b0;
                            state_q       <= S_PREP;
                        end
                    end
                end

                S_PREP: begin
                    rem_q   <= '0;
                    quo_q   <= a_mag;
                    dsr_q   <= d_mag;
                    qsign_q <= a_neg ^ d_neg;
`ifdef DIVISAO_RESTO_EN
                    rsign_q <= a_neg;
`endif
                    cnt_q   <= '0;
                    state_q <= S_DIV;
                end

                S_DIV: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(W - 1)) begin
                        state_q <= S_WRITE;
                    end
                end

                S_WRITE: begin
                    nova_matriz_A[int'(idx_q)*W +: W] <= q_signed;
`ifdef DIVISAO_RESTO_EN
                    resto_matriz_A[int'(idx_q)*W +: W] <= r_signed;
`endif
                    if (ovf_elem) begin
                        overflow_flag <= 1'b1;
                    end
                    if (idx_q == IDX_W'(N_ELEM - 1)) begin
                        done    <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        idx_q   <= idx_q + IDX_W'(1);
                        state_q <= S_PREP;
                    end
                end

                S_DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_q <= S_IDLE;
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule
